// File: rtl/flash_boot_copier_pkg.sv
// Shared definitions for the flash-to-SRAM boot copier.
// Holds the bus widths, the FSM state encoding, and a small state decode helper.
package flash_boot_copier_pkg;

  localparam int FLASH_AW = 22;  // flash halfword address width
  localparam int FLASH_DW = 16;  // flash data width (x16 mode)
  localparam int RAM_AW   = 20;  // SRAM word address width
  localparam int DW       = 32;  // SRAM data / checksum width
  localparam int IDX_W    = 21;  // word index; must hold COPY_WORDS up to 2^20
  localparam int CNT_W    = 16;  // wait counter width

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RPWAIT,
    ST_RD_LO,
    ST_RD_HI,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_DONE
  } state_e;

  // The copier owns both buses in every state except IDLE and DONE.
  function automatic logic is_copying(state_e s);
    return !(s == ST_IDLE || s == ST_DONE);
  endfunction

endpackage

// File: rtl/flash_boot_copier_if.sv
// Flash and base-SRAM pin bundle driven by the boot copier.
// master: the copier (drives addresses, strobes, write data; reads flash data).
// slave : the memory side / bus mux (drives flash_data_in).
interface flash_boot_copier_if;
  import flash_boot_copier_pkg::*;

  logic [FLASH_AW-1:0] flash_address;
  logic [FLASH_DW-1:0] flash_data_in;
  logic                flash_ce_n;
  logic                flash_oe_n;
  logic                flash_we_n;
  logic                flash_byte_n;
  logic                flash_rp_n;
  logic [RAM_AW-1:0]   ram_addr;
  logic [DW-1:0]       ram_wdata;
  logic                ram_wdata_oe;
  logic                ram_ce_n;
  logic                ram_oe_n;
  logic                ram_we_n;

  modport master (
    output flash_address, flash_ce_n, flash_oe_n, flash_we_n, flash_byte_n, flash_rp_n,
    output ram_addr, ram_wdata, ram_wdata_oe, ram_ce_n, ram_oe_n, ram_we_n,
    input  flash_data_in
  );

  modport slave (
    input  flash_address, flash_ce_n, flash_oe_n, flash_we_n, flash_byte_n, flash_rp_n,
    input  ram_addr, ram_wdata, ram_wdata_oe, ram_ce_n, ram_oe_n, ram_we_n,
    output flash_data_in
  );
endinterface

// File: rtl/flash_boot_copier_wait_cnt.sv
// Generic loadable down-counter used for the reset-pin wait, flash read access
// time and SRAM write pulse width.
// Ports: clk, rst_n (async active-low), load_i/load_val_i (load a count),
//        dec_i (count down, saturating at zero), zero_o (count is zero).
module flash_boot_copier_wait_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/flash_boot_copier.sv
// Boot-time copy engine: reads COPY_WORDS 32-bit words from the x16 NOR flash
// (low halfword first), writes them to base SRAM, then releases the CPU reset.
// Ports: clk, rst_n (async active-low); start (restart pulse, IDLE/DONE only);
//        auto_start (copy on first cycle after reset); own_bus/busy/done/
//        cpu_rst_n status; checksum (wrapping sum of copied words);
//        dbg_state (current FSM state); bus (flash + SRAM pins, master side).
// All bus-facing outputs are registered, decoded from the next state.
module flash_boot_copier
  import flash_boot_copier_pkg::*;
#(
  parameter logic [FLASH_AW-1:0] FLASH_BASE   = 22'h0,
  parameter logic [RAM_AW-1:0]   RAM_BASE     = 20'h0,
  parameter int unsigned         COPY_WORDS   = 1024,
  parameter int                  FLASH_RD_CYC = 6,
  parameter int                  RAM_WE_CYC   = 2,
  parameter int                  RP_WAIT_CYC  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            auto_start,
  output logic            own_bus,
  output logic            cpu_rst_n,
  output logic            busy,
  output logic            done,
  output logic [DW-1:0]   checksum,
  output state_e          dbg_state,
  flash_boot_copier_if.master bus
);
  // A state lasting N cycles loads N-1 on entry and leaves when the counter hits zero.
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'((FLASH_RD_CYC > 1) ? FLASH_RD_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] WE_LOAD = CNT_W'((RAM_WE_CYC   > 1) ? RAM_WE_CYC   - 1 : 0);
  localparam logic [CNT_W-1:0] RP_LOAD = CNT_W'((RP_WAIT_CYC  > 1) ? RP_WAIT_CYC  - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COPY_WORDS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DW-1:0]    word_q, word_d;
  logic [DW-1:0]    checksum_q, checksum_d;
  logic             first_q;     // high only on the first clock after reset
  logic             cnt_load, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;

  flash_boot_copier_wait_cnt #(.W(CNT_W)) u_wait_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (cnt_load),
    .load_val_i(cnt_load_val),
    .dec_i     (!cnt_load),
    .zero_o    (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    word_d     = word_q;
    checksum_d = checksum_q;
    case (state_q)
      ST_IDLE:     if ((auto_start && first_q) || start) state_d = ST_RPWAIT;
      ST_RPWAIT: begin
        idx_d      = '0;
        checksum_d = '0;
        if (cnt_zero) state_d = ST_RD_LO;
      end
      ST_RD_LO: if (cnt_zero) begin
        word_d[15:0] = bus.flash_data_in;
        state_d      = ST_RD_HI;
      end
      ST_RD_HI: if (cnt_zero) begin
        word_d[31:16] = bus.flash_data_in;
        state_d       = ST_WR_SETUP;
      end
      ST_WR_SETUP: state_d = ST_WR_PULSE;
      ST_WR_PULSE: if (cnt_zero) state_d = ST_WR_HOLD;
      ST_WR_HOLD: begin
        checksum_d = checksum_q + word_q;
        idx_d      = idx_q + 1'b1;
        state_d    = (idx_q == LAST_IDX) ? ST_DONE : ST_RD_LO;
      end
      ST_DONE:     if (start) state_d = ST_RPWAIT;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Any state change reloads the wait counter with the length of the new state.
  always_comb begin
    cnt_load     = (state_d != state_q);
    cnt_load_val = '0;
    case (state_d)
      ST_RPWAIT:          cnt_load_val = RP_LOAD;
      ST_RD_LO, ST_RD_HI: cnt_load_val = RD_LOAD;
      ST_WR_PULSE:        cnt_load_val = WE_LOAD;
      default:            cnt_load_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      idx_q            <= '0;
      word_q           <= '0;
      checksum_q       <= '0;
      first_q          <= 1'b1;
      own_bus          <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      cpu_rst_n        <= 1'b0;
      bus.flash_rp_n   <= 1'b0;
      bus.flash_ce_n   <= 1'b1;
      bus.flash_oe_n   <= 1'b1;
      bus.flash_address <= '0;
      bus.ram_addr     <= '0;
      bus.ram_wdata    <= '0;
      bus.ram_wdata_oe <= 1'b0;
      bus.ram_ce_n     <= 1'b1;
      bus.ram_we_n     <= 1'b1;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      word_q         <= word_d;
      checksum_q     <= checksum_d;
      first_q        <= 1'b0;
      own_bus        <= is_copying(state_d);
      busy           <= is_copying(state_d);
      done           <= (state_d == ST_DONE);
      cpu_rst_n      <= (state_d == ST_DONE);
      bus.flash_rp_n <= 1'b1;
      // CE/OE stay low across the LO->HI boundary; only the address LSB changes.
      bus.flash_ce_n <= !(state_d == ST_RD_LO || state_d == ST_RD_HI);
      bus.flash_oe_n <= !(state_d == ST_RD_LO || state_d == ST_RD_HI);
      if (state_d == ST_RD_LO) bus.flash_address <= FLASH_BASE + {idx_d, 1'b0};
      if (state_d == ST_RD_HI) bus.flash_address <= FLASH_BASE + {idx_d, 1'b1};
      // Address and data are latched once at setup and held through the hold cycle.
      if (state_d == ST_WR_SETUP) begin
        bus.ram_addr  <= RAM_BASE + idx_d[RAM_AW-1:0];
        bus.ram_wdata <= word_d;
      end
      bus.ram_wdata_oe <= (state_d == ST_WR_SETUP || state_d == ST_WR_PULSE ||
                           state_d == ST_WR_HOLD);
      bus.ram_ce_n     <= !(state_d == ST_WR_SETUP || state_d == ST_WR_PULSE ||
                            state_d == ST_WR_HOLD);
      bus.ram_we_n     <= !(state_d == ST_WR_PULSE);
    end
  end

  // Read-only x16 flash access; SRAM is never read by this block.
  assign bus.flash_we_n   = 1'b1;
  assign bus.flash_byte_n = 1'b1;
  assign bus.ram_oe_n     = 1'b1;

  assign checksum  = checksum_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_flash_boot_copier.sv
// Bench for flash_boot_copier: 4-word copy into an SRAM window that wraps at
// the top of the 20-bit address space, with a flash model, a write scoreboard
// and per-cycle bus invariants.
module tb_flash_boot_copier;
  import flash_boot_copier_pkg::*;

  localparam int RD = 6;
  localparam int WE = 2;
  localparam int RP = 4;
  localparam int NW = 4;
  localparam logic [19:0] RB = 20'hFFFFE;
  localparam int WORD_CYC = 2 * RD + WE + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic auto_start = 1'b0;
  always #5 clk = ~clk;

  logic        own_bus, cpu_rst_n, busy, done;
  logic [31:0] checksum;
  state_e      dbg_state;

  flash_boot_copier_if bus();

  flash_boot_copier #(
    .FLASH_BASE  (22'h0),
    .RAM_BASE    (RB),
    .COPY_WORDS  (NW),
    .FLASH_RD_CYC(RD),
    .RAM_WE_CYC  (WE),
    .RP_WAIT_CYC (RP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .auto_start(auto_start),
    .own_bus   (own_bus),
    .cpu_rst_n (cpu_rst_n),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum),
    .dbg_state (dbg_state),
    .bus       (bus)
  );

  // ---------------- stimulus table + flash model ----------------
  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic [19:0] addr;
    logic [31:0] word;
  } vec_t;
  vec_t vecs[NW];

  logic [15:0] flash_mem[8];
  assign bus.flash_data_in = (bus.flash_address < 22'd8) ? flash_mem[bus.flash_address[2:0]]
                                                        : 16'hDEAD;

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [51:0] exp_q[$];
  logic [31:0] ram_mem[int];
  logic [31:0] exp_sum;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_expected();
    exp_q.delete();
    ram_mem.delete();
    for (int i = 0; i < NW; i++) exp_q.push_back({vecs[i].addr, vecs[i].word});
  endtask

  // ---------------- bus monitor ----------------
  int cyc = 0;
  int we_low = 0;
  int ce_low = 0;
  int last_hold = 0;
  int n_writes = 0;
  bit hold_seen = 0;
  logic prev_we = 1'b1, prev_rce = 1'b1, prev_fce = 1'b1;
  logic [19:0] setup_addr;
  logic [31:0] setup_data;

  always @(negedge clk) begin
    logic [51:0] e;
    cyc++;
    check("inv_wdata_oe_needs_own_bus", 32'(bus.ram_wdata_oe && !own_bus), 0);
    check("inv_flash_we_n_high", 32'(bus.flash_we_n), 1);
    check("inv_ram_we_oe_not_both_low", 32'(!bus.ram_we_n && !bus.ram_oe_n), 0);

    if (!bus.flash_ce_n) ce_low++;
    else begin
      if (!prev_fce) check("flash_ce_low_cycles", ce_low, 2 * RD);
      ce_low = 0;
    end

    if (!bus.ram_ce_n && prev_rce) begin
      setup_addr = bus.ram_addr;
      setup_data = bus.ram_wdata;
      check("setup_we_n_high", 32'(bus.ram_we_n), 1);
      check("setup_wdata_oe", 32'(bus.ram_wdata_oe), 1);
    end else if (!bus.ram_ce_n && !bus.ram_we_n) begin
      we_low++;
      check("pulse_addr_stable", bus.ram_addr, setup_addr);
      check("pulse_data_stable", bus.ram_wdata, setup_data);
    end else if (!bus.ram_ce_n && bus.ram_we_n && !prev_we) begin
      check("we_low_cycles", we_low, WE);
      check("hold_addr_stable", bus.ram_addr, setup_addr);
      check("hold_data_stable", bus.ram_wdata, setup_data);
      check("hold_wdata_oe", 32'(bus.ram_wdata_oe), 1);
      if (exp_q.size() == 0) check("unexpected_write", 32'(bus.ram_addr), 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        check("ram_addr", bus.ram_addr, e[51:32]);
        check("ram_wdata", bus.ram_wdata, e[31:0]);
      end
      ram_mem[int'(bus.ram_addr)] = bus.ram_wdata;
      n_writes++;
      if (hold_seen) check("cycles_per_word", cyc - last_hold, WORD_CYC);
      last_hold = cyc;
      hold_seen = 1;
    end
    if (bus.ram_ce_n) we_low = 0;
    if (bus.ram_ce_n && bus.flash_ce_n) hold_seen = 0;
    prev_we  = bus.ram_we_n;
    prev_rce = bus.ram_ce_n;
    prev_fce = bus.flash_ce_n;
  end

  // ---------------- driver / check tasks ----------------
  task automatic reset_checks(string tag);
    check({tag, "_own_bus"}, 32'(own_bus), 0);
    check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_checksum"}, checksum, 0);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    check({tag, "_flash_ce_n"}, 32'(bus.flash_ce_n), 1);
    check({tag, "_flash_oe_n"}, 32'(bus.flash_oe_n), 1);
    check({tag, "_flash_byte_n"}, 32'(bus.flash_byte_n), 1);
    check({tag, "_flash_rp_n"}, 32'(bus.flash_rp_n), 0);
    check({tag, "_flash_address"}, 32'(bus.flash_address), 0);
    check({tag, "_ram_ce_n"}, 32'(bus.ram_ce_n), 1);
    check({tag, "_ram_we_n"}, 32'(bus.ram_we_n), 1);
    check({tag, "_ram_oe_n"}, 32'(bus.ram_oe_n), 1);
    check({tag, "_ram_addr"}, 32'(bus.ram_addr), 0);
    check({tag, "_ram_wdata"}, bus.ram_wdata, 0);
    check({tag, "_ram_wdata_oe"}, 32'(bus.ram_wdata_oe), 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(string tag, int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done_within_budget"}, 32'(done), 1);
  endtask

  task automatic check_done(string tag);
    check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 1);
    check({tag, "_own_bus"}, 32'(own_bus), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_DONE));
    check({tag, "_checksum"}, checksum, exp_sum);
    check({tag, "_wdata_oe"}, 32'(bus.ram_wdata_oe), 0);
    check({tag, "_ram_ce_n"}, 32'(bus.ram_ce_n), 1);
    check({tag, "_flash_ce_n"}, 32'(bus.flash_ce_n), 1);
    check({tag, "_pending_writes"}, exp_q.size(), 0);
    for (int i = 0; i < NW; i++) begin
      if (ram_mem.exists(int'(vecs[i].addr)))
        check({tag, "_ram_content"}, ram_mem[int'(vecs[i].addr)], vecs[i].word);
      else
        check({tag, "_ram_written"}, 32'(vecs[i].addr) | 32'h8000_0000, 32'(vecs[i].addr));
    end
  endtask

  task automatic check_running(string tag);
    check({tag, "_busy"}, 32'(busy), 1);
    check({tag, "_own_bus"}, 32'(own_bus), 1);
    check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 0);
    check({tag, "_done"}, 32'(done), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    int w0;
    int bad;

    vecs[0] = '{16'h1111, 16'h2222, 20'hFFFFE, 32'h2222_1111};
    vecs[1] = '{16'h3333, 16'h4444, 20'hFFFFF, 32'h4444_3333};
    vecs[2] = '{16'h5555, 16'h6666, 20'h00000, 32'h6666_5555};
    vecs[3] = '{16'h7777, 16'h8888, 20'h00001, 32'h8888_7777};
    exp_sum = '0;
    for (int i = 0; i < NW; i++) begin
      flash_mem[2 * i]     = vecs[i].lo;
      flash_mem[2 * i + 1] = vecs[i].hi;
      exp_sum += vecs[i].word;
    end

    // Reset state, then auto-started copy.
    auto_start = 1'b1;
    repeat (3) @(negedge clk);
    reset_checks("rst");
    push_expected();
    rst_n = 1'b1;
    @(negedge clk);
    check_running("auto_start");
    check("rp_n_released", 32'(bus.flash_rp_n), 1);
    k = 0;
    while (bus.flash_ce_n && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("rp_wait_cycles", k, RP);
    wait_done("copy1", 200);
    check_done("copy1");

    // start from DONE restarts; reset during the 3rd write pulse aborts it.
    push_expected();
    pulse_start();
    check_running("restart_from_done");
    w0 = n_writes;
    k = 0;
    while (!(n_writes == w0 + 2 && !bus.ram_we_n) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("third_pulse_reached", n_writes - w0, 2);
    check("third_pulse_we_low", 32'(bus.ram_we_n), 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_we_n", 32'(bus.ram_we_n), 1);
    check("midrst_own_bus", 32'(own_bus), 0);
    check("midrst_wdata_oe", 32'(bus.ram_wdata_oe), 0);
    check("midrst_ram_ce_n", 32'(bus.ram_ce_n), 1);
    check("midrst_checksum", checksum, 0);
    check("midrst_rp_n", 32'(bus.flash_rp_n), 0);
    push_expected();
    @(negedge clk);
    rst_n = 1'b1;
    wait_done("copy_after_reset", 200);
    check_done("copy_after_reset");

    // Manual start: idle until a start pulse; a start pulse mid-copy is ignored.
    auto_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (own_bus || cpu_rst_n || busy || done || !bus.flash_rp_n) bad++;
    end
    check("idle_cycles_with_activity", bad, 0);
    check("idle_state", 32'(dbg_state), 32'(ST_IDLE));
    push_expected();
    pulse_start();
    check_running("manual_start");
    repeat (30) @(negedge clk);
    check("midcopy_busy_before_start", 32'(busy), 1);
    pulse_start();
    check_running("midcopy_start_ignored");
    wait_done("copy_manual", 200);
    check_done("copy_manual");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish (limit 100000 ns)");
    $fatal(1, "timeout");
  end
endmodule
